imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/cpu_pkg.sv | 18 +
 rtl/imm_pack.sv | 68 ++++++
 rtl/imm_encoder.sv | 99 +++++++++
 tb/tb_imm_encoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ==========================================================================
// cpu_pkg: shared core definitions; ImmSrc format encodings.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package cpu_pkg;

  typedef logic [1:0] imm_src_t;

  localparam imm_src_t IMM_I = 2'b00;
  localparam imm_src_t IMM_S = 2'b01;
  localparam imm_src_t IMM_B = 2'b10;
  localparam imm_src_t IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ==========================================================================
// imm_pack: combinational immediate bit packing and range detection.
// Optional feature macro: IMM_ENCODER_RANGE_CHECK_EN
// Revision: 1.0
// ==========================================================================
`default_nettype none

module imm_pack
  import cpu_pkg::*;
(
  input  logic [1:0]  imm_src,
  input  logic [31:0] imm_val,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        range_err
);

  always_comb begin
    instr = base;
    case (imm_src)
      IMM_I: instr[31:20] = imm_val[11:0];
      IMM_S: begin
        instr[31:25] = imm_val[11:5];
        instr[11:7]  = imm_val[4:0];
      end
      IMM_B: begin
        instr[31]    = imm_val[12];
        instr[7]     = imm_val[11];
        instr[30:25] = imm_val[10:5];
        instr[11:8]  = imm_val[4:1];
      end
      default: begin
        instr[31]    = imm_val[20];
        instr[19:12] = imm_val[19:12];
        instr[20]    = imm_val[11];
        instr[30:21] = imm_val[10:1];
      end
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // A field is representable when every bit above it equals its sign bit.
  logic w_ovf_11;
  logic w_ovf_12;
  logic w_ovf_20;

  assign w_ovf_11 = ~((&imm_val[31:11]) | ~(|imm_val[31:11]));
  assign w_ovf_12 = ~((&imm_val[31:12]) | ~(|imm_val[31:12]));
  assign w_ovf_20 = ~((&imm_val[31:20]) | ~(|imm_val[31:20]));

  always_comb begin
    range_err = 1'b0;
    case (imm_src)
      IMM_I, IMM_S: range_err = w_ovf_11;
      IMM_B:        range_err = w_ovf_12 | imm_val[0];
      default:      range_err = w_ovf_20 | imm_val[0];
    endcase
  end
`else
  logic w_unused_hi;

  assign w_unused_hi = &{1'b0, imm_val[31:21]};
  assign range_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ==========================================================================
// imm_encoder: valid/ready immediate encoder with registered output and
// saturating counters. Optional feature macro: IMM_ENCODER_RANGE_CHECK_EN
// Revision: 1.0
// ==========================================================================
`default_nettype none

module imm_encoder
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSrc,
  input  logic [31:0]      ImmVal,
  input  logic [31:0]      Base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr,
  output logic             RangeErr,
  output logic [CNT_W-1:0] EncCount,
  output logic [CNT_W-1:0] ErrCount
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      w_instr;
  logic             w_range_err;
  logic             w_in_ready;
  logic             w_accept;
  logic             r_out_valid;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_enc_cnt;

  imm_pack u_imm_pack (
    .imm_src   (ImmSrc),
    .imm_val   (ImmVal),
    .base      (Base),
    .instr     (w_instr),
    .range_err (w_range_err)
  );

  // Reset gates in_ready so nothing can be accepted while rst_n is low.
  assign w_in_ready = rst_n & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= 32'h0;
      r_enc_cnt   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_instr     <= w_instr;
      if (r_enc_cnt != '1) begin
        r_enc_cnt <= r_enc_cnt + c_cnt_one;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic             r_range_err;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_range_err <= 1'b0;
      r_err_cnt   <= '0;
    end else if (w_accept) begin
      r_range_err <= w_range_err;
      if (w_range_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + c_cnt_one;
      end
    end
  end

  assign RangeErr = r_range_err;
  assign ErrCount = r_err_cnt;
`else
  logic w_unused_err;

  assign w_unused_err = w_range_err;
  assign RangeErr     = 1'b0;
  assign ErrCount     = '0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign Instr     = r_instr;
  assign EncCount  = r_enc_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ==========================================================================
// tb_imm_encoder: scoreboard bench for imm_encoder (both range-check builds).
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_imm_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    ImmSrc;
  logic [31:0]   ImmVal;
  logic [31:0]   Base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   Instr;
  logic          RangeErr;
  logic [CW-1:0] EncCount;
  logic [CW-1:0] ErrCount;

  imm_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ImmSrc    (ImmSrc),
    .ImmVal    (ImmVal),
    .Base      (Base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Instr     (Instr),
    .RangeErr  (RangeErr),
    .EncCount  (EncCount),
    .ErrCount  (ErrCount)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_model(input logic [1:0] src, input logic [31:0] imm,
                                            input logic [31:0] base);
    case (src)
      2'b00:   return (base & 32'h000FFFFF) | {imm[11:0], 20'b0};
      2'b01:   return (base & 32'h01FFF07F) | {imm[11:5], 13'b0, imm[4:0], 7'b0};
      2'b10:   return (base & 32'h01FFF07F) | {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      default: return (base & 32'h00000FFF) | {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] i, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic fits(input logic [1:0] src, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (src)
      2'b00, 2'b01: return (s >= -2048) && (s <= 2047);
      2'b10:        return (s >= -4096) && (s <= 4095) && !imm[0];
      default:      return (s >= -1048576) && (s <= 1048575) && !imm[0];
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  src;
    logic [31:0] imm;
    logic        in_range;
    logic        has_lit;
    logic [31:0] lit;
  } entry_t;

  entry_t        sb[$];
  logic          m_valid = 1'b0;
  logic [CW-1:0] m_enc   = '0;
  logic [CW-1:0] m_err   = '0;
  logic          cur_has_lit = 1'b0;
  logic [31:0]   cur_lit     = 32'h0;

  // Reference model: compares the current outputs, then advances the
  // expected state for the coming rising edge.
  always @(negedge clk) begin
    logic   exp_rdy;
    entry_t e;
    exp_rdy = rst_n && (!m_valid || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("enc_cnt", {28'b0, EncCount}, {28'b0, m_enc});
    chk("err_cnt", {28'b0, ErrCount}, {28'b0, m_err});
    if (m_valid && sb.size() != 0) begin
      e = sb[0];
      chk("instr", Instr, e.instr);
      chk("range_err", {31'b0, RangeErr}, {31'b0, e.err});
      if (e.has_lit) chk("instr_lit", Instr, e.lit);
      if (e.in_range) chk("decode", decode(Instr, e.src), e.imm);
    end
    if (!rst_n) begin
      sb.delete();
      m_valid = 1'b0;
      m_enc   = '0;
      m_err   = '0;
    end else begin
      if (m_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
      if (in_valid && exp_rdy) begin
        e.src      = ImmSrc;
        e.imm      = ImmVal;
        e.instr    = enc_model(ImmSrc, ImmVal, Base);
        e.in_range = fits(ImmSrc, ImmVal);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
        e.err      = !e.in_range;
`else
        e.err      = 1'b0;
`endif
        e.has_lit  = cur_has_lit;
        e.lit      = cur_lit;
        sb.push_back(e);
        if (m_enc != '1) m_enc = m_enc + 1'b1;
        if (e.err && m_err != '1) m_err = m_err + 1'b1;
      end
      m_valid = (sb.size() != 0);
    end
  end

  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                      input logic has_lit, input logic [31:0] lit);
    int n;
    ImmSrc = src; ImmVal = imm; Base = base;
    cur_has_lit = has_lit; cur_lit = lit;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cur_has_lit = 1'b0;
    ImmVal = $urandom;
    Base   = $urandom;
  endtask

  logic done_rand;

  initial begin
    logic [31:0] r;
    logic [31:0] exp_a;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ImmSrc = 2'b00; ImmVal = 32'h0; Base = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_err", {31'b0, RangeErr}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(2'b00, 32'hFFFFFFFF, 32'h00000013, 1'b1, 32'hFFF00013);
    send(2'b01, 32'h00000008, 32'h00002023, 1'b1, 32'h00002423);
    send(2'b10, 32'hFFFFFFFC, 32'h00000063, 1'b1, 32'hFE000EE3);
    send(2'b11, 32'h00000800, 32'h0000006F, 1'b1, 32'h0010006F);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
    send(2'b00, 32'h00000800, 32'h00000013, 1'b1, 32'h80000013);
    @(negedge clk);
    chk("err_vec_flag", {31'b0, RangeErr}, 32'd1);
    chk("err_vec_cnt", {28'b0, ErrCount}, 32'd1);
`else
    send(2'b00, 32'h00000800, 32'h00000013, 1'b1, 32'h80000013);
`endif
    send(2'b10, 32'h00000003, 32'hFFFFFFFF, 1'b0, 32'h0);
    send(2'b11, 32'hFFF00000, 32'h12345678, 1'b0, 32'h0);

    // Random traffic with random backpressure; long enough to saturate.
    done_rand = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          r = $urandom;
          case ($urandom_range(0, 2))
            1:       r = {{20{r[11]}}, r[11:1], 1'b0};
            2:       r = {{11{r[20]}}, r[20:1], 1'b0};
            default: ;
          endcase
          send(2'($urandom_range(0, 3)), r, $urandom, 1'b0, 32'h0);
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Reset while a word is stalled on the output.
    #1;
    out_ready = 1'b0;
    send(2'b00, 32'h00000005, 32'h00000013, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_instr", Instr, 32'h0);
    chk("mid_rst_err", {31'b0, RangeErr}, 32'h0);
    chk("mid_rst_enc", {28'b0, EncCount}, 32'h0);
    chk("mid_rst_errc", {28'b0, ErrCount}, 32'h0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back A then B under a 3-cycle stall.
    exp_a = enc_model(2'b01, 32'hFFFFFFF0, 32'h00001023);
    ImmSrc = 2'b01; ImmVal = 32'hFFFFFFF0; Base = 32'h00001023;
    in_valid = 1'b1;
    @(posedge clk); #1;
    ImmSrc = 2'b10; ImmVal = 32'h00000010; Base = 32'h00000063;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_hold", Instr, exp_a);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_cnt", {28'b0, EncCount}, 32'd2);
    chk("bp_drained", {31'b0, out_valid}, 32'h0);

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
